// File: rtl/cva6_rvfi_retire_tracker_if.sv
// Probe-in / RVFI-out bundle for cva6_rvfi_retire_tracker.
// The tracker takes the slave modport; whoever drives the core probes takes master.
interface cva6_rvfi_retire_tracker_if #(
    parameter int unsigned NR_ISSUE_PORTS  = 1,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned VLEN            = 64,
    parameter int unsigned PLEN            = 56
) ();
    logic                                             flush_i;
    logic [NR_ISSUE_PORTS-1:0]                        decoded_instr_valid_i;
    logic [NR_ISSUE_PORTS-1:0]                        decoded_instr_ack_i;
    logic [NR_ISSUE_PORTS-1:0][TRANS_ID_BITS-1:0]     issue_pointer_i;
    logic [NR_ISSUE_PORTS-1:0][31:0]                  instruction_i;
    logic [NR_ISSUE_PORTS-1:0]                        is_compressed_i;
    logic [NR_ISSUE_PORTS-1:0][VLEN-1:0]              rs1_forwarding_i;
    logic [NR_ISSUE_PORTS-1:0][VLEN-1:0]              rs2_forwarding_i;
    logic                                             lsu_valid_i;
    logic [TRANS_ID_BITS-1:0]                         lsu_trans_id_i;
    logic [VLEN-1:0]                                  lsu_vaddr_i;
    logic [PLEN-1:0]                                  lsu_paddr_i;
    logic [XLEN/8-1:0]                                lsu_be_i;
    logic                                             lsu_is_store_i;
    logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0]    commit_pointer_i;
    logic [NR_COMMIT_PORTS-1:0]                       commit_instr_valid_i;
    logic [NR_COMMIT_PORTS-1:0]                       commit_ack_i;
    logic [NR_COMMIT_PORTS-1:0]                       commit_drop_i;
    logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]             commit_pc_i;
    logic [NR_COMMIT_PORTS-1:0][4:0]                  commit_rs1_i;
    logic [NR_COMMIT_PORTS-1:0][4:0]                  commit_rs2_i;
    logic [NR_COMMIT_PORTS-1:0][4:0]                  commit_rd_i;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]             wdata_i;
    logic                                             ex_commit_valid_i;
    logic [XLEN-1:0]                                  ex_commit_cause_i;
    logic [1:0]                                       priv_lvl_i;

    logic [NR_COMMIT_PORTS-1:0]                       rvfi_valid_o;
    logic [NR_COMMIT_PORTS-1:0][63:0]                 rvfi_order_o;
    logic [NR_COMMIT_PORTS-1:0][31:0]                 rvfi_insn_o;
    logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]             rvfi_pc_o;
    logic [NR_COMMIT_PORTS-1:0][4:0]                  rvfi_rs1_addr_o;
    logic [NR_COMMIT_PORTS-1:0][4:0]                  rvfi_rs2_addr_o;
    logic [NR_COMMIT_PORTS-1:0][4:0]                  rvfi_rd_addr_o;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]             rvfi_rs1_rdata_o;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]             rvfi_rs2_rdata_o;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]             rvfi_rd_wdata_o;
    logic [NR_COMMIT_PORTS-1:0]                       rvfi_trap_o;
    logic [XLEN-1:0]                                  rvfi_cause_o;
    logic [1:0]                                       rvfi_mode_o;
    logic [NR_COMMIT_PORTS-1:0][PLEN-1:0]             rvfi_mem_addr_o;
    logic [NR_COMMIT_PORTS-1:0][XLEN/8-1:0]           rvfi_mem_rmask_o;
    logic [NR_COMMIT_PORTS-1:0][XLEN/8-1:0]           rvfi_mem_wmask_o;
    logic                                             miss_o;

    modport slave (
        input  flush_i, decoded_instr_valid_i, decoded_instr_ack_i, issue_pointer_i,
               instruction_i, is_compressed_i, rs1_forwarding_i, rs2_forwarding_i,
               lsu_valid_i, lsu_trans_id_i, lsu_vaddr_i, lsu_paddr_i, lsu_be_i, lsu_is_store_i,
               commit_pointer_i, commit_instr_valid_i, commit_ack_i, commit_drop_i, commit_pc_i,
               commit_rs1_i, commit_rs2_i, commit_rd_i, wdata_i,
               ex_commit_valid_i, ex_commit_cause_i, priv_lvl_i,
        output rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_pc_o,
               rvfi_rs1_addr_o, rvfi_rs2_addr_o, rvfi_rd_addr_o,
               rvfi_rs1_rdata_o, rvfi_rs2_rdata_o, rvfi_rd_wdata_o,
               rvfi_trap_o, rvfi_cause_o, rvfi_mode_o,
               rvfi_mem_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o, miss_o
    );

    modport master (
        output flush_i, decoded_instr_valid_i, decoded_instr_ack_i, issue_pointer_i,
               instruction_i, is_compressed_i, rs1_forwarding_i, rs2_forwarding_i,
               lsu_valid_i, lsu_trans_id_i, lsu_vaddr_i, lsu_paddr_i, lsu_be_i, lsu_is_store_i,
               commit_pointer_i, commit_instr_valid_i, commit_ack_i, commit_drop_i, commit_pc_i,
               commit_rs1_i, commit_rs2_i, commit_rd_i, wdata_i,
               ex_commit_valid_i, ex_commit_cause_i, priv_lvl_i,
        input  rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_pc_o,
               rvfi_rs1_addr_o, rvfi_rs2_addr_o, rvfi_rd_addr_o,
               rvfi_rs1_rdata_o, rvfi_rs2_rdata_o, rvfi_rd_wdata_o,
               rvfi_trap_o, rvfi_cause_o, rvfi_mode_o,
               rvfi_mem_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o, miss_o
    );
endinterface

// File: rtl/cva6_rvfi_retire_tracker.sv
// Rebuilds one RVFI record per commit port by joining issue-time data (by trans ID) to commit data.
// CVA6_RVFI_MEM_EN builds the LSU mem table; without it the memory fields read 0.
module cva6_rvfi_retire_tracker #(
    parameter int unsigned NR_ISSUE_PORTS  = 1,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned VLEN            = 64,
    parameter int unsigned PLEN            = 56
) (
    input logic                     clk_i,
    input logic                     rst_i,
    cva6_rvfi_retire_tracker_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** TRANS_ID_BITS;

    typedef struct packed {
        logic [31:0]     insn;
        logic            compressed;
        logic [VLEN-1:0] rs1;
        logic [VLEN-1:0] rs2;
    } issue_entry_t;

    issue_entry_t               issue_q [DEPTH];
    logic [DEPTH-1:0]           issue_vld_q;

    logic [NR_COMMIT_PORTS-1:0]       retire, release_slot, hit;
    logic [NR_COMMIT_PORTS-1:0][63:0] order_d;
    logic [63:0]                      order_q, order_nxt;

    // An exception on port 0 retires it regardless of ack/drop.
    always_comb begin
        retire       = '0;
        release_slot = '0;
        hit          = '0;
        order_d      = '0;
        order_nxt    = order_q;
        for (int c = 0; c < NR_COMMIT_PORTS; c++) begin
            release_slot[c] = bus.commit_instr_valid_i[c] &
                              (bus.commit_ack_i[c] | (c == 0 && bus.ex_commit_valid_i));
            retire[c]       = bus.commit_instr_valid_i[c] &
                              ((bus.commit_ack_i[c] & ~bus.commit_drop_i[c]) |
                               (c == 0 && bus.ex_commit_valid_i));
            hit[c]          = issue_vld_q[bus.commit_pointer_i[c]];
            order_d[c]      = order_nxt;
            order_nxt       = order_nxt + 64'(retire[c]);
        end
    end

    // Later assignments win: commit clear, then flush, then a fresh issue write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_vld_q <= '0;
        end else begin
            for (int c = 0; c < NR_COMMIT_PORTS; c++)
                if (release_slot[c]) issue_vld_q[bus.commit_pointer_i[c]] <= 1'b0;
            if (bus.flush_i) issue_vld_q <= '0;
            for (int p = 0; p < NR_ISSUE_PORTS; p++) begin
                if (bus.decoded_instr_valid_i[p] && bus.decoded_instr_ack_i[p] && !bus.flush_i) begin
                    issue_vld_q[bus.issue_pointer_i[p]] <= 1'b1;
                    issue_q[bus.issue_pointer_i[p]]     <= '{insn:       bus.instruction_i[p],
                                                             compressed: bus.is_compressed_i[p],
                                                             rs1:        bus.rs1_forwarding_i[p],
                                                             rs2:        bus.rs2_forwarding_i[p]};
                end
            end
        end
    end

`ifdef CVA6_RVFI_MEM_EN
    typedef struct packed {
        logic [PLEN-1:0]   paddr;
        logic [XLEN/8-1:0] be;
        logic              is_store;
    } mem_entry_t;

    mem_entry_t       mem_q [DEPTH];
    logic [DEPTH-1:0] mem_vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_vld_q <= '0;
        end else begin
            for (int c = 0; c < NR_COMMIT_PORTS; c++)
                if (release_slot[c]) mem_vld_q[bus.commit_pointer_i[c]] <= 1'b0;
            if (bus.lsu_valid_i) begin
                mem_q[bus.lsu_trans_id_i] <= '{paddr: bus.lsu_paddr_i, be: bus.lsu_be_i,
                                               is_store: bus.lsu_is_store_i};
                mem_vld_q[bus.lsu_trans_id_i] <= 1'b1;
            end
            if (bus.flush_i) mem_vld_q <= '0;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            order_q              <= '0;
            bus.miss_o           <= 1'b0;
            bus.rvfi_valid_o     <= '0;
            bus.rvfi_order_o     <= '0;
            bus.rvfi_insn_o      <= '0;
            bus.rvfi_pc_o        <= '0;
            bus.rvfi_rs1_addr_o  <= '0;
            bus.rvfi_rs2_addr_o  <= '0;
            bus.rvfi_rd_addr_o   <= '0;
            bus.rvfi_rs1_rdata_o <= '0;
            bus.rvfi_rs2_rdata_o <= '0;
            bus.rvfi_rd_wdata_o  <= '0;
            bus.rvfi_trap_o      <= '0;
            bus.rvfi_cause_o     <= '0;
            bus.rvfi_mode_o      <= '0;
            bus.rvfi_mem_addr_o  <= '0;
            bus.rvfi_mem_rmask_o <= '0;
            bus.rvfi_mem_wmask_o <= '0;
        end else begin
            order_q          <= order_nxt;
            bus.miss_o       <= bus.miss_o | (|(retire & ~hit));
            bus.rvfi_valid_o <= retire;
            bus.rvfi_trap_o  <= NR_COMMIT_PORTS'(bus.ex_commit_valid_i);
            bus.rvfi_cause_o <= bus.ex_commit_valid_i ? bus.ex_commit_cause_i : '0;
            bus.rvfi_mode_o  <= bus.priv_lvl_i;
            for (int c = 0; c < NR_COMMIT_PORTS; c++) begin
                bus.rvfi_order_o[c]     <= order_d[c];
                bus.rvfi_pc_o[c]        <= bus.commit_pc_i[c];
                bus.rvfi_rs1_addr_o[c]  <= bus.commit_rs1_i[c];
                bus.rvfi_rs2_addr_o[c]  <= bus.commit_rs2_i[c];
                bus.rvfi_rd_addr_o[c]   <= bus.commit_rd_i[c];
                bus.rvfi_rd_wdata_o[c]  <= (bus.commit_rd_i[c] == 5'd0) ? '0 : bus.wdata_i[c];
                bus.rvfi_insn_o[c]      <= hit[c] ? issue_q[bus.commit_pointer_i[c]].insn : '0;
                bus.rvfi_rs1_rdata_o[c] <= hit[c] ? issue_q[bus.commit_pointer_i[c]].rs1  : '0;
                bus.rvfi_rs2_rdata_o[c] <= hit[c] ? issue_q[bus.commit_pointer_i[c]].rs2  : '0;
`ifdef CVA6_RVFI_MEM_EN
                if (mem_vld_q[bus.commit_pointer_i[c]]) begin
                    bus.rvfi_mem_addr_o[c]  <= mem_q[bus.commit_pointer_i[c]].paddr;
                    bus.rvfi_mem_rmask_o[c] <= mem_q[bus.commit_pointer_i[c]].is_store ?
                                               '0 : mem_q[bus.commit_pointer_i[c]].be;
                    bus.rvfi_mem_wmask_o[c] <= mem_q[bus.commit_pointer_i[c]].is_store ?
                                               mem_q[bus.commit_pointer_i[c]].be : '0;
                end else begin
                    bus.rvfi_mem_addr_o[c]  <= '0;
                    bus.rvfi_mem_rmask_o[c] <= '0;
                    bus.rvfi_mem_wmask_o[c] <= '0;
                end
`else
                bus.rvfi_mem_addr_o[c]  <= '0;
                bus.rvfi_mem_rmask_o[c] <= '0;
                bus.rvfi_mem_wmask_o[c] <= '0;
`endif
            end
        end
    end
endmodule

// File: doc/cva6_rvfi_retire_tracker.md
Name: cva6_rvfi_retire_tracker

Overview:
Consumer end of the RVFI probe bundle. Takes the flattened issue, commit and LSU probe fields and rebuilds one RVFI retirement record per commit port. Issue-time data is held in a table indexed by scoreboard transaction ID and joined to commit-time data. Sits in the verification harness next to the core; records feed the tracer and the ISS comparator.

Parameters:
NR_ISSUE_PORTS, 1, issue ports probed
NR_COMMIT_PORTS, 2, commit ports probed / RVFI channels emitted
TRANS_ID_BITS, 3, scoreboard index width; table depth = 2**TRANS_ID_BITS
XLEN, 64, integer data width
VLEN, 64, virtual address / PC width
PLEN, 56, physical address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush; invalidates the issue table
decoded_instr_valid_i  in  NR_ISSUE_PORTS  decoded instruction valid
decoded_instr_ack_i  in  NR_ISSUE_PORTS  decoded instruction accepted by issue
issue_pointer_i  in  NR_ISSUE_PORTS x TRANS_ID_BITS  scoreboard slot being issued
instruction_i  in  NR_ISSUE_PORTS x 32  raw instruction bits
is_compressed_i  in  NR_ISSUE_PORTS  16-bit instruction
rs1_forwarding_i / rs2_forwarding_i  in  NR_ISSUE_PORTS x VLEN  operand values at issue
lsu_valid_i  in  1  LSU request valid this cycle
lsu_trans_id_i  in  TRANS_ID_BITS  LSU request slot
lsu_vaddr_i  in  VLEN  LSU virtual address
lsu_paddr_i  in  PLEN  LSU physical address
lsu_be_i  in  XLEN/8  byte enables
lsu_is_store_i  in  1  1 = store, 0 = load
commit_pointer_i  in  NR_COMMIT_PORTS x TRANS_ID_BITS  slot committing
commit_instr_valid_i  in  NR_COMMIT_PORTS  commit entry valid
commit_ack_i  in  NR_COMMIT_PORTS  entry retired
commit_drop_i  in  NR_COMMIT_PORTS  entry retired silently; no record
commit_pc_i  in  NR_COMMIT_PORTS x VLEN  PC
commit_rs1_i / commit_rs2_i / commit_rd_i  in  NR_COMMIT_PORTS x 5  register indices
wdata_i  in  NR_COMMIT_PORTS x XLEN  writeback data
ex_commit_valid_i  in  1  exception on commit port 0
ex_commit_cause_i  in  XLEN  exception cause
priv_lvl_i  in  2  privilege level
rvfi_valid_o  out  NR_COMMIT_PORTS  record valid (one-cycle pulse per record)
rvfi_order_o  out  NR_COMMIT_PORTS x 64  retirement order
rvfi_insn_o  out  NR_COMMIT_PORTS x 32  instruction bits
rvfi_pc_o  out  NR_COMMIT_PORTS x VLEN  PC
rvfi_rs1_addr_o / rvfi_rs2_addr_o / rvfi_rd_addr_o  out  NR_COMMIT_PORTS x 5  register indices
rvfi_rs1_rdata_o / rvfi_rs2_rdata_o / rvfi_rd_wdata_o  out  NR_COMMIT_PORTS x XLEN  register data
rvfi_trap_o  out  NR_COMMIT_PORTS  trap flag
rvfi_cause_o  out  XLEN  trap cause (port 0 only)
rvfi_mode_o  out  2  privilege level at retirement
rvfi_mem_addr_o  out  NR_COMMIT_PORTS x PLEN  memory address
rvfi_mem_rmask_o / rvfi_mem_wmask_o  out  NR_COMMIT_PORTS x XLEN/8  memory masks
miss_o  out  1  sticky: a commit found no issue-table entry

Behaviour:
- Reset: every output register is 0, order counter is 0, all table valid bits are 0, miss_o is 0.
- Issue capture: for port p, when decoded_instr_valid_i[p] & decoded_instr_ack_i[p] & !flush_i, write {insn, compressed, rs1, rs2} to entry issue_pointer_i[p] and set its valid bit. Entry 0 of the issue table corresponds to slot 0.
- LSU capture: when lsu_valid_i, write {paddr, be, is_store} to mem entry lsu_trans_id_i and set the mem-valid bit.
- Retire condition for port c: retire[c] = commit_ack_i[c] & commit_instr_valid_i[c] & !commit_drop_i[c].
- Exception retire: ex_commit_valid_i & commit_instr_valid_i[0] retires port 0 even when commit_ack_i[0]=0.
- Outputs are registered. A record appears exactly 1 cycle after its retire condition and rvfi_valid_o is high for that one cycle.
- Field rules:
  - rvfi_rd_wdata = 0 when rd = 0.
  - rvfi_trap[0] = ex_commit_valid_i; rvfi_trap[c>0] = 0.
  - Memory fields are taken from the mem entry when mem-valid is set: rmask = be for a load, wmask = be for a store. Otherwise memory fields are 0.
- Order:
  - rvfi_order[c] = order counter + (number of retiring ports below c).
  - The counter then advances by popcount(retire).
  - The counter is 64-bit and wraps modulo 2^64.
- Table clear: a retired or dropped entry's valid and mem-valid bits clear on the commit edge.
  - If an issue write hits the same index in the same cycle, the write wins and valid stays 1.
  - A commit read on that index returns the old contents (read-before-write).
- Flush: all valid and mem-valid bits clear. Commits in the flush cycle still produce records, using the pre-flush contents.
- Missing entry: a retire whose entry has valid=0 still emits a record with insn = 0 and operand data = 0, and sets miss_o.
  - miss_o stays set until reset.
- Reset mid-operation: records in flight are lost; rvfi_valid_o is 0 on the cycle after reset is asserted.

Optional Feature:
CVA6_RVFI_MEM_EN
- Defined: the mem table and LSU capture are built, as described above.
- Undefined: no mem table is built, the lsu_* inputs are ignored, and rvfi_mem_addr_o, rvfi_mem_rmask_o and rvfi_mem_wmask_o are tied to 0.

Test Plan:
1. Issue insn 0x00500093 at slot 2 with rs1=0x11; commit port 0 at pointer 2, rd=1, wdata=5 -> next cycle: valid[0]=1, order=0, insn=0x00500093, rs1_rdata=0x11, rd_wdata=5.
2. Both ports retire in the same cycle (slots 3, 4) after 1 prior retirement -> orders 1 and 2; counter becomes 3.
3. Load at slot 5: lsu_paddr=0x80001000, be=0x0F, load; commit -> mem_addr=0x80001000, rmask=0x0F, wmask=0 (macro defined); with the macro undefined, all memory fields are 0.
4. ex_commit_valid=1, cause=2, commit_ack[0]=0 -> trap[0]=1, cause=2, valid[0]=1; commit_drop[1]=1 in the same cycle -> valid[1]=0.
5. Flush after issuing slot 6, then commit slot 6 -> record with insn=0 and miss_o=1, which stays high until rst_i.
6. Issue write to slot 7 and commit of slot 7 in the same cycle -> record shows the old entry; slot 7 remains valid with the new data.
